// File: rtl/vmem_port_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vmem_port_pkg : shared bus types and helpers for memory bus masters  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package vmem_port_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_t;

  // Burst length uses AXI encoding: beats minus one.
  typedef logic [7:0] mlen_t;
  localparam mlen_t MLEN1 = 8'd0;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic        is_write;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  function automatic logic addr_misaligned(input logic [63:0] addr, input msize_t size);
    logic w_bad;
    w_bad = 1'b0;
    case (size)
      MSIZE2:  w_bad = addr[0];
      MSIZE4:  w_bad = |addr[1:0];
      MSIZE8:  w_bad = |addr[2:0];
      default: w_bad = 1'b0;
    endcase
    return w_bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vmem_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vmem_port : single-outstanding virtual memory port; translates,      |
// |             checks alignment, then issues one beat on the shared bus |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module vmem_port
  import vmem_port_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_write,
  input  msize_t      req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  output logic        resp_error,
  output logic        mmu_req_valid,
  output logic [63:0] mmu_req_vaddr,
  input  logic        mmu_resp_valid,
  input  logic [63:0] mmu_resp_paddr,
  input  cbus_req_t   mmu_creq,
  output cbus_resp_t  mmu_cresp,
  output cbus_req_t   creq,
  input  cbus_resp_t  cresp
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] XLATE = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  r_state;
  logic [63:0] r_vaddr;
  logic [63:0] r_paddr;
  logic        r_write;
  msize_t      r_size;
  logic [7:0]  r_strobe;
  logic [63:0] r_wdata;
  logic [63:0] r_resp_data;
  logic        r_resp_error;
  cbus_req_t   r_creq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_vaddr      <= '0;
      r_paddr      <= '0;
      r_write      <= 1'b0;
      r_size       <= MSIZE1;
      r_strobe     <= '0;
      r_wdata      <= '0;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
      r_creq       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_vaddr  <= req_addr;
            r_write  <= req_write;
            r_size   <= req_size;
            r_strobe <= req_strobe;
            r_wdata  <= req_data;
            r_state  <= XLATE;
          end
        end
        XLATE: begin
          if (mmu_resp_valid) begin
            r_paddr <= mmu_resp_paddr;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          // Misaligned accesses never reach the bus.
          if (addr_misaligned(r_paddr, r_size)) begin
            r_resp_error <= 1'b1;
            r_resp_data  <= '0;
            r_state      <= DONE;
          end else begin
            r_creq.valid    <= 1'b1;
            r_creq.addr     <= r_paddr;
            r_creq.size     <= r_size;
            r_creq.is_write <= r_write;
            r_creq.strobe   <= r_write ? r_strobe : 8'h00;
            r_creq.data     <= r_wdata;
            r_creq.len      <= MLEN1;
            r_creq.burst    <= AXI_BURST_FIXED;
            r_state         <= DATA;
          end
        end
        DATA: begin
          if (cresp.last) begin
            r_resp_data  <= r_write ? 64'd0 : cresp.data;
            r_resp_error <= 1'b0;
            r_creq       <= '0;
            r_state      <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The translator owns the shared bus for the whole walk.
  assign creq          = (r_state == XLATE) ? mmu_creq : r_creq;
  assign mmu_cresp     = (r_state == XLATE) ? cresp : '0;

  assign req_ready     = (r_state == IDLE);
  assign mmu_req_valid = (r_state == XLATE);
  assign mmu_req_vaddr = r_vaddr;
  assign resp_valid    = (r_state == DONE);
  assign resp_data     = r_resp_data;
  assign resp_error    = r_resp_error;

endmodule
`default_nettype wire

// File: tb/tb_vmem_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vmem_port : scoreboard bench for vmem_port                        |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_vmem_port;
  import vmem_port_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_write;
  msize_t      req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_error;
  logic        mmu_req_valid;
  logic [63:0] mmu_req_vaddr;
  logic        mmu_resp_valid;
  logic [63:0] mmu_resp_paddr;
  cbus_req_t   mmu_creq;
  cbus_resp_t  mmu_cresp;
  cbus_req_t   creq;
  cbus_resp_t  cresp;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  logic prev_rv = 1'b0;

  vmem_port dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_strobe(req_strobe),
    .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .mmu_req_valid(mmu_req_valid), .mmu_req_vaddr(mmu_req_vaddr),
    .mmu_resp_valid(mmu_resp_valid), .mmu_resp_paddr(mmu_resp_paddr),
    .mmu_creq(mmu_creq), .mmu_cresp(mmu_cresp),
    .creq(creq), .cresp(cresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every resp_valid pops one expectation.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb.size() == 0) begin
        check_eq("resp_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("resp_data", resp_data, e.data);
        check_eq("resp_error", {63'd0, resp_error}, {63'd0, e.err});
      end
      if (prev_rv) check_eq("resp_one_cycle", 64'd1, 64'd0);
    end
    prev_rv = resp_valid;
  end

  task automatic send(input logic [63:0] addr, input logic wr, input msize_t sz,
                      input logic [7:0] strb, input logic [63:0] data,
                      input logic [63:0] exp_data, input logic exp_err);
    exp_t e;
    @(negedge clk);
    check_eq("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_write  = wr;
    req_size   = sz;
    req_strobe = strb;
    req_data   = data;
    e.data = exp_data;
    e.err  = exp_err;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("accept_to_xlate", {63'd0, mmu_req_valid}, 64'd1);
  endtask

  task automatic mmu_answer(input logic [63:0] vaddr, input logic [63:0] paddr, input int lat);
    int n = 0;
    while (!mmu_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("mmu_req_seen", {63'd0, mmu_req_valid}, 64'd1);
    check_eq("mmu_vaddr", mmu_req_vaddr, vaddr);
    repeat (lat) begin
      @(negedge clk);
      check_eq("no_data_in_xlate", {63'd0, creq.valid}, 64'd0);
    end
    mmu_resp_valid = 1'b1;
    mmu_resp_paddr = paddr;
    @(negedge clk);
    mmu_resp_valid = 1'b0;
    check_eq("mmu_req_drop", {63'd0, mmu_req_valid}, 64'd0);
  endtask

  task automatic bus_answer(input logic [63:0] addr, input logic wr, input msize_t sz,
                            input logic [7:0] strb, input logic [63:0] wdata,
                            input int lat, input logic [63:0] rdata);
    int n = 0;
    while (!creq.valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("creq_valid", {63'd0, creq.valid}, 64'd1);
    check_eq("creq_addr", creq.addr, addr);
    check_eq("creq_write", {63'd0, creq.is_write}, {63'd0, wr});
    check_eq("creq_size", {62'd0, creq.size}, {62'd0, sz});
    check_eq("creq_strobe", {56'd0, creq.strobe}, {56'd0, strb});
    check_eq("creq_data", creq.data, wdata);
    check_eq("creq_len_burst", {54'd0, creq.len, creq.burst}, {54'd0, MLEN1, AXI_BURST_FIXED});
    repeat (lat) @(negedge clk);
    cresp.valid = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = rdata;
    @(negedge clk);
    cresp = '0;
    check_eq("creq_clear", {63'd0, creq.valid}, 64'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", {32'd0, sb.size()}, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_size = MSIZE1;
    req_strobe = '0; req_data = '0;
    mmu_resp_valid = 1'b0; mmu_resp_paddr = '0;
    mmu_creq = '0; cresp = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {63'd0, req_ready}, 64'd1);
    check_eq("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check_eq("rst_mmu_valid", {63'd0, mmu_req_valid}, 64'd0);
    check_eq("rst_creq", {63'd0, creq == '0}, 64'd1);
    check_eq("rst_mmu_cresp", {63'd0, mmu_cresp == '0}, 64'd1);

    // Bare read; strobe on a read must be suppressed on the bus.
    send(64'h8000_0010, 1'b0, MSIZE8, 8'hFF, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0);
    mmu_answer(64'h8000_0010, 64'h8000_0010, 2);
    bus_answer(64'h8000_0010, 1'b0, MSIZE8, 8'h00, 64'h0, 1, 64'hDEAD_BEEF_0123_4567);
    wait_drain();
    check_eq("hold_data", resp_data, 64'hDEAD_BEEF_0123_4567);

    // Page walk routed through the port, cresp.last during the walk ignored.
    send(64'h0000_4000_0020, 1'b0, MSIZE4, 8'h00, 64'h0, 64'h0000_0000_CAFE_F00D, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mmu_creq       = '0;
      mmu_creq.valid = 1'b1;
      mmu_creq.addr  = 64'h8010_0000 + 64'(i * 8);
      mmu_creq.size  = MSIZE8;
      cresp.valid    = 1'b1;
      cresp.last     = 1'b1;
      cresp.data     = 64'h2000_0000_0000_0C01 + 64'(i);
      #1;
      check_eq("walk_creq", {63'd0, creq === mmu_creq}, 64'd1);
      check_eq("walk_cresp", mmu_cresp.data, 64'h2000_0000_0000_0C01 + 64'(i));
      check_eq("walk_cresp_last", {63'd0, mmu_cresp.last}, 64'd1);
      @(negedge clk);
    end
    mmu_creq = '0;
    cresp = '0;
    mmu_answer(64'h0000_4000_0020, 64'h8000_2020, 1);
    bus_answer(64'h8000_2020, 1'b0, MSIZE4, 8'h00, 64'h0, 2, 64'h0000_0000_CAFE_F00D);
    wait_drain();
    check_eq("idle_mmu_cresp", {63'd0, mmu_cresp == '0}, 64'd1);

    // Aligned 4-byte write; response data reads back as zero.
    send(64'h0000_1004, 1'b1, MSIZE4, 8'h0F, 64'h1122_3344, 64'h0, 1'b0);
    mmu_answer(64'h0000_1004, 64'h8000_0004, 0);
    bus_answer(64'h8000_0004, 1'b1, MSIZE4, 8'h0F, 64'h1122_3344, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_drain();

    // Misaligned 8-byte read: error, and the bus stays quiet.
    send(64'h8000_0003, 1'b0, MSIZE8, 8'h00, 64'h0, 64'h0, 1'b1);
    mmu_answer(64'h8000_0003, 64'h8000_0003, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq("misalign_no_bus", {63'd0, creq.valid}, 64'd0);
      @(negedge clk);
    end
    wait_drain();
    check_eq("hold_error", {63'd0, resp_error}, 64'd1);

    // Reset in the middle of the data phase.
    send(64'h8000_0040, 1'b0, MSIZE8, 8'h00, 64'h0, 64'h0, 1'b0);
    mmu_answer(64'h8000_0040, 64'h8000_0040, 0);
    for (int n = 0; n < 20 && !creq.valid; n++) @(negedge clk);
    check_eq("pre_rst_creq_valid", {63'd0, creq.valid}, 64'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_creq", {63'd0, creq == '0}, 64'd1);
    check_eq("mid_rst_ready", {63'd0, req_ready}, 64'd1);
    check_eq("mid_rst_error", {63'd0, resp_error}, 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    send(64'h8000_0048, 1'b0, MSIZE2, 8'h00, 64'h0, 64'h0000_0000_0000_ABCD, 1'b0);
    mmu_answer(64'h8000_0048, 64'h8000_0048, 1);
    bus_answer(64'h8000_0048, 1'b0, MSIZE2, 8'h00, 64'h0, 1, 64'h0000_0000_0000_ABCD);
    wait_drain();

    // req_valid held high: second request taken only after DONE.
    begin
      exp_t e;
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 64'h0000_A000; req_write = 1'b0;
      req_size = MSIZE8; req_strobe = 8'h00; req_data = 64'h0;
      e.data = 64'h1111_2222_3333_4444; e.err = 1'b0; sb.push_back(e);
      e.data = 64'h5555_6666_7777_8888; e.err = 1'b0; sb.push_back(e);
      @(negedge clk);
      req_addr = 64'h0000_B000;
      mmu_answer(64'h0000_A000, 64'h8000_A000, 2);
      check_eq("busy_not_ready", {63'd0, req_ready}, 64'd0);
      bus_answer(64'h8000_A000, 1'b0, MSIZE8, 8'h00, 64'h0, 1, 64'h1111_2222_3333_4444);
      while (!resp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_eq("hold_first_resp", {63'd0, resp_valid}, 64'd1);
      check_eq("done_not_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      check_eq("after_done_ready", {63'd0, req_ready}, 64'd1);
      check_eq("after_done_no_xlate", {63'd0, mmu_req_valid}, 64'd0);
      @(negedge clk);
      req_valid = 1'b0;
      mmu_answer(64'h0000_B000, 64'h8000_B000, 1);
      bus_answer(64'h8000_B000, 1'b0, MSIZE8, 8'h00, 64'h0, 0, 64'h5555_6666_7777_8888);
      wait_drain();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vmem_port.md
VMEM_PORT -- requirements
Module: vmem_port

Interface
REQ-001 SHALL have parameter: none; all widths fixed; bus types come from the common package (cbus_req_t, cbus_resp_t, msize_t).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req_valid in 1, req_ready out 1, req_addr in 64 (virtual), req_write in 1, req_size in msize_t, req_strobe in 8, req_data in 64: pipeline memory request.
REQ-005 SHALL have ports: resp_valid out 1, resp_data out 64, resp_error out 1: pipeline response.
REQ-006 SHALL have ports: mmu_req_valid out 1, mmu_req_vaddr out 64, mmu_resp_valid in 1, mmu_resp_paddr in 64: translator handshake.
REQ-007 SHALL have ports: mmu_creq in cbus_req_t, mmu_cresp out cbus_resp_t: translator page-walk bus, routed through this block.
REQ-008 SHALL have ports: creq out cbus_req_t, cresp in cbus_resp_t: single shared memory bus.

Function
REQ-009 SHALL implement FSM states IDLE, XLATE, ISSUE, DATA, DONE.
REQ-010 SHALL assert req_ready only in IDLE; request accepted when req_valid&&req_ready; all req_* fields latched that edge; IDLE->XLATE.
REQ-011 SHALL drive mmu_req_valid=1 exactly while in XLATE; mmu_req_vaddr = latched address.
REQ-012 SHALL in XLATE pass mmu_creq to creq and cresp to mmu_cresp combinationally; in all other states mmu_cresp='0.
REQ-013 SHALL in XLATE on mmu_resp_valid latch mmu_resp_paddr, go ISSUE; mmu_req_valid deasserts that same transition.
REQ-014 SHALL in ISSUE check alignment: paddr low bits nonzero for size (MSIZE2: bit0; MSIZE4: bits1:0; MSIZE8: bits2:0) -> resp_error latched 1, go DONE, no bus access; else go DATA.
REQ-015 SHALL in DATA drive registered creq: valid=1, addr=paddr, size=latched size, is_write, strobe (forced 0 on read), data, len=MLEN1, burst=AXI_BURST_FIXED.
REQ-016 SHALL in DATA on cresp.last latch cresp.data (reads only), clear creq to '0 the next cycle, go DONE.
REQ-017 SHALL in DONE assert resp_valid for exactly one cycle with resp_data/resp_error; DONE->IDLE unconditionally.
REQ-018 SHALL hold resp_data and resp_error stable outside DONE until the next DONE overwrites them; resp_data=0 on writes and errors.
REQ-019 SHALL ignore req_valid outside IDLE; no queueing; a new request can be accepted the cycle after DONE at earliest.
REQ-020 SHALL ignore mmu_resp_valid outside XLATE and cresp.last outside DATA.
REQ-021 SHALL give min latency accept->resp_valid = 1 + MMU latency + 1 + bus latency + 1 cycles.

Reset
REQ-022 SHALL on reset (any cycle, including mid-walk or mid-DATA) enter IDLE, clear creq, resp_data, resp_error, latched request and paddr to 0; outstanding transaction abandoned, the bus and MMU share the same reset.
REQ-023 SHALL have reset output values: req_ready=1 after reset, resp_valid=0, mmu_req_valid=0, creq='0, mmu_cresp='0.

Structure
REQ-024 SHALL keep the state enum local; the misalignment-check helper function SHALL live in the common package for reuse by other bus masters.
REQ-025 SHALL be a single module; instantiation of the translator is the parent's job, no sub-module inside.

Verification
REQ-026 Bare mode, read 8B at 0x8000_0010, MMU resp 2 cycles later paddr=0x8000_0010, bus returns 0xDEAD_BEEF_0123_4567 with last -> resp_valid one cycle, resp_data matches, resp_error=0.
REQ-027 Sv39 walk: during XLATE three mmu_creq reads appear on creq verbatim and mmu_cresp mirrors cresp; no data request issued before mmu_resp_valid.
REQ-028 Write 4B at paddr 0x8000_0004, strobe 0x0F, data 0x1122_3344 -> creq.is_write=1, strobe 0x0F, addr 0x8000_0004; resp_valid after last, resp_data=0.
REQ-029 Read 8B at paddr 0x8000_0003 -> resp_error=1, creq.valid never asserted after XLATE.
REQ-030 Reset asserted in DATA with creq.valid=1 -> next edge creq='0, req_ready=1; following request completes normally.
REQ-031 req_valid held high through DONE -> second request accepted only in the cycle after resp_valid, never during XLATE/DATA.
